// File: rtl/pret_pkg.sv
// pret_pkg: shared widths, capture FSM states and the result rounding helper for pret and its result buffer
package pret_pkg;
  localparam int PRET_W = 6;
  localparam int PRET_N = 2;
  localparam int PRET_NC = 1;
  localparam int PRET_TW = PRET_W * PRET_N + PRET_NC;
  localparam int PRET_OW = 6;
  localparam int PRET_DEPTH = 4;
  localparam int PRET_CW = 16;
  typedef enum logic [1:0] {IDLE, RUN, HOLD} pret_buf_state_e;
  // Round-half-up from tw to ow bits, saturating; one guard bit above 32 catches the carry-out.
  function automatic logic [31:0] round_sat(input logic [31:0] bz, input int unsigned tw, input int unsigned ow);
    logic [32:0] sum;
    logic [32:0] max_v;
    int unsigned s;
    s = tw - ow;
    max_v = (33'd1 << ow) - 33'd1;
    if (s == 0) return bz;
    sum = ({1'b0, bz} + (33'd1 << (s - 1))) >> s;
    return (sum > max_v) ? max_v[31:0] : sum[31:0];
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO
// ports: push_i/data_i write side (ignored when full unless popping), ready_i pops the head when valid_o,
//        data_o head (0 when empty), full_o, level_o occupancy; async active-low rst_n clears pointers and level
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     ready_i,
  output logic                     valid_o,
  output logic                     full_o,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] level_q, level_d;
  logic wr_en, rd_en;
  assign valid_o = level_q != '0;
  assign full_o = level_q == (AW+1)'(DEPTH);
  assign rd_en = valid_o & ready_i;
  // a full FIFO still accepts when the head leaves in the same cycle
  assign wr_en = push_i & (~full_o | rd_en);
  assign data_o = valid_o ? mem_q[rd_q] : '0;
  assign level_o = level_q;
  always_comb begin
    wr_d = wr_en ? wr_q + AW'(1) : wr_q;
    rd_d = rd_en ? rd_q + AW'(1) : rd_q;
    level_d = level_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= data_i;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      level_q <= level_d;
    end
  end
endmodule

// File: rtl/pret_result_buf.sv
// pret_result_buf: captures each finished pret run as {rounded Bz, run length} into a drainable FIFO
// ports: start_i marks a run start, done_i/bz_i from pret, out_valid_o/out_ready_i/out_val_o/out_cycles_o head handshake,
//        overflow_o sticky drop flag, level_o occupancy; async active-low rst_n
module pret_result_buf import pret_pkg::*; #(
  parameter int TW = PRET_TW,
  parameter int OW = PRET_OW,
  parameter int DEPTH = PRET_DEPTH,
  parameter int CW = PRET_CW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic                     done_i,
  input  logic [TW-1:0]            bz_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [OW-1:0]            out_val_o,
  output logic [CW-1:0]            out_cycles_o,
  output logic                     overflow_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  pret_buf_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cycles;
  logic done_q, overflow_q, overflow_d, push, full;
  logic [OW-1:0] rnd;
  logic [OW+CW-1:0] head;
  assign push = (state_q == RUN) & done_i & ~done_q;
  assign cycles = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
  assign rnd = OW'(round_sat(32'(bz_i), TW, OW));
  // start wins over capture for the next state; the capture itself still uses the old count
  always_comb begin
    state_d = start_i ? RUN : push ? HOLD : state_q;
    cnt_d = start_i ? '0 : (state_q == RUN && cnt_q != '1) ? cnt_q + CW'(1) : cnt_q;
    overflow_d = overflow_q | (push & full & ~(out_valid_o & out_ready_i));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      done_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      done_q <= done_i;
      overflow_q <= overflow_d;
    end
  end
  sync_fifo #(.WIDTH(OW + CW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  ({rnd, cycles}),
    .ready_i (out_ready_i),
    .valid_o (out_valid_o),
    .full_o  (full),
    .data_o  (head),
    .level_o (level_o)
  );
  assign out_val_o = head[OW+CW-1:CW];
  assign out_cycles_o = head[CW-1:0];
  assign overflow_o = overflow_q;
endmodule

// File: tb/tb_pret_result_buf.sv
// tb_pret_result_buf: table-driven and scoreboarded checks of pret_result_buf (default, OW=TW and CW=4 builds)
module tb_pret_result_buf;
  logic clk = 1'b0, rst_n, start, done, out_ready;
  logic [12:0] bz;
  logic valid, ovf, p_valid, p_ovf, c_valid, c_ovf;
  logic [5:0] val;
  logic [15:0] cyc;
  logic [12:0] p_val;
  logic [15:0] p_cyc;
  logic [5:0] c_val;
  logic [3:0] c_cyc;
  logic [2:0] level, p_level, c_level;
  int n_cmp = 0, n_err = 0;
  logic exp_ovf;
  typedef struct { logic [12:0] bz; int len; logic [5:0] v6; } vec_t;
  typedef struct { logic [5:0] v6; logic [12:0] v13; int cyc; } exp_t;
  exp_t q[$];
  vec_t tbl[7];
  always #5 clk = ~clk;
  pret_result_buf dut (.clk(clk), .rst_n(rst_n), .start_i(start), .done_i(done), .bz_i(bz),
    .out_valid_o(valid), .out_ready_i(out_ready), .out_val_o(val), .out_cycles_o(cyc),
    .overflow_o(ovf), .level_o(level));
  pret_result_buf #(.OW(13)) dut_p (.clk(clk), .rst_n(rst_n), .start_i(start), .done_i(done), .bz_i(bz),
    .out_valid_o(p_valid), .out_ready_i(out_ready), .out_val_o(p_val), .out_cycles_o(p_cyc),
    .overflow_o(p_ovf), .level_o(p_level));
  pret_result_buf #(.CW(4)) dut_c (.clk(clk), .rst_n(rst_n), .start_i(start), .done_i(done), .bz_i(bz),
    .out_valid_o(c_valid), .out_ready_i(out_ready), .out_val_o(c_val), .out_cycles_o(c_cyc),
    .overflow_o(c_ovf), .level_o(c_level));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_push(input logic [12:0] b, input int len, input logic [5:0] v);
    exp_t e;
    e.v6 = v;
    e.v13 = b;
    e.cyc = len;
    if (q.size() >= 4) exp_ovf = 1'b1;
    else q.push_back(e);
    chk("level_after_push", 32'(level), q.size());
    chk("overflow", 32'(ovf), 32'(exp_ovf));
    if (q.size() != 0) chk("valid_after_push", 32'(valid), 1);
  endtask
  task automatic run(input logic [12:0] b, input int len, input logic [5:0] v, input logic rk);
    start = 1'b1;
    done = 1'b0;
    step();
    start = 1'b0;
    repeat (len - 1) step();
    done = 1'b1;
    bz = b;
    if (rk) out_ready = 1'b1;
    step();
    if (rk) out_ready = 1'b0;
    expect_push(b, len, v);
  endtask
  always @(negedge clk) begin
    if (rst_n && valid && out_ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_entry: got val %0d cycles %0d expected none", val, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_val", 32'(val), 32'(e.v6));
        chk("out_val_ow13", 32'(p_val), 32'(e.v13));
        chk("out_cycles", 32'(cyc), e.cyc);
        chk("out_cycles_cw4", 32'(c_cyc), (e.cyc > 15) ? 15 : e.cyc);
        chk("valid_ow13", 32'(p_valid), 1);
        chk("valid_cw4", 32'(c_valid), 1);
      end
    end
  end
  initial begin
    tbl[0] = '{13'h0800, 64, 6'd16};
    tbl[1] = '{13'h003F, 3, 6'd0};
    tbl[2] = '{13'h0040, 5, 6'd1};
    tbl[3] = '{13'h1FFF, 2, 6'd63};
    tbl[4] = '{13'h0ABC, 7, 6'd21};
    tbl[5] = '{13'h0FE0, 20, 6'd32};
    tbl[6] = '{13'h1FC0, 1, 6'd63};
    rst_n = 1'b0;
    start = 1'b0;
    done = 1'b0;
    bz = '0;
    out_ready = 1'b0;
    exp_ovf = 1'b0;
    repeat (2) step();
    chk("rst_valid", 32'(valid), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_overflow", 32'(ovf), 0);
    chk("rst_out_val", 32'(val), 0);
    chk("rst_out_cycles", 32'(cyc), 0);
    rst_n = 1'b1;
    done = 1'b1;
    bz = 13'h0800;
    repeat (3) step();
    chk("idle_rise_level", 32'(level), 0);
    done = 1'b0;
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      run(tbl[i].bz, tbl[i].len, tbl[i].v6, 1'b0);
      repeat (2) step();
    end
    repeat (20) step();
    chk("hold_level", 32'(level), 0);
    done = 1'b0;
    step();
    done = 1'b1;
    repeat (3) step();
    chk("hold_rise_level", 32'(level), 0);
    start = 1'b1;
    done = 1'b0;
    step();
    start = 1'b0;
    repeat (9) step();
    start = 1'b1;
    done = 1'b1;
    bz = 13'h0800;
    step();
    expect_push(13'h0800, 10, 6'd16);
    start = 1'b0;
    done = 1'b0;
    repeat (4) step();
    done = 1'b1;
    bz = 13'h0040;
    step();
    expect_push(13'h0040, 5, 6'd1);
    repeat (3) step();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) run(13'h0040, 3 + i, 6'd1, 1'b0);
    chk("full_level", 32'(level), 4);
    chk("full_overflow", 32'(ovf), 1);
    run(13'h0FE0, 2, 6'd32, 1'b1);
    chk("push_pop_full_level", 32'(level), 4);
    out_ready = 1'b1;
    repeat (8) step();
    chk("drained_level", 32'(level), 0);
    chk("drained_model", q.size(), 0);
    chk("overflow_sticky", 32'(ovf), 1);
    out_ready = 1'b0;
    run(13'h0800, 4, 6'd16, 1'b0);
    run(13'h003F, 6, 6'd0, 1'b0);
    chk("two_queued", 32'(level), 2);
    start = 1'b1;
    done = 1'b0;
    step();
    start = 1'b0;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(valid), 0);
    chk("arst_level", 32'(level), 0);
    chk("arst_overflow", 32'(ovf), 0);
    chk("arst_out_val", 32'(val), 0);
    q.delete();
    exp_ovf = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    done = 1'b1;
    bz = 13'h0800;
    repeat (3) step();
    chk("post_rst_rise_level", 32'(level), 0);
    chk("post_rst_rise_valid", 32'(valid), 0);
    out_ready = 1'b1;
    run(13'h0040, 4, 6'd1, 1'b0);
    repeat (3) step();
    chk("final_model", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pret_result_buf.md
# pret_result_buf

Downstream capture stage for `pret`. It watches `pret`'s `done` and accumulated `Bz`, and on each completed run it does three things: rounds `Bz` to an `OW`-bit result, pairs it with the run's cycle count (the early-termination latency), and buffers the pair in a small FIFO. A valid/ready port drains the FIFO to the consumer, which is either the host-side collector or the next compute stage.

## Interface
Parameters:
- `TW`, 13: width of `Bz`. Matches `pret`'s `TW` (W*N+NC with W=6, N=2, NC=1).
- `OW`, 6: output result width. Must satisfy 1 <= OW <= TW.
- `DEPTH`, 4: FIFO entries. Must be a power of two, >= 2.
- `CW`, 16: cycle-counter width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; marks the cycle a new `pret` run begins.
- `done`  in  1  from `pret`; held high once the run finishes, until `pret` is reset.
- `Bz`  in  TW  from `pret`; valid whenever `done`=1.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer accepts the head.
- `out_val`  out  OW  rounded result at the head.
- `out_cycles`  out  CW  run length at the head.
- `overflow`  out  1  sticky; a result was dropped because the FIFO was full.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- FSM states:
  - IDLE: reset state.
  - RUN: run in progress, counting.
  - HOLD: result captured, waiting for the next `start`.
- Transitions:
  - `start`=1 in any state: go to RUN, clear `cnt` to 0. A `start` during RUN abandons the current run with no push.
  - RUN with a `done` rising edge (`done`=1 and registered `done_q`=0): push one entry, go to HOLD.
  - `start` and a `done` rise in the same RUN cycle: push the old run's entry first (using the old `cnt`), then stay in RUN with `cnt` cleared to 0.
  - A `done` rise in IDLE or HOLD is ignored. Only one capture happens per `start`.
- Counter: `cnt` increments every cycle in RUN and saturates at 2^CW-1. The pushed cycle value is `cnt`+1, also saturating.
- Rounding, with S = TW-OW:
  - `out_val` = min((Bz + 2^(S-1)) >> S, 2^OW-1).
  - Compute with one extra bit to catch carry-out.
  - When S = 0, pass `Bz` through unchanged.
- FIFO behaviour:
  - First-word-fall-through. `out_valid` = (`level` != 0). The head is presented combinationally from storage.
  - Pop when `out_valid` && `out_ready`.
  - Push while full with no pop in the same cycle: drop the entry, set `overflow`.
  - Push while full with a simultaneous pop: accept the push; `level` is unchanged.
  - Pointers wrap modulo DEPTH.
  - `out_ready` while empty has no effect.
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - `cnt`, `done_q`, pointers, `level` and `overflow` go to 0.
  - `out_valid`=0; `out_val` and `out_cycles` read 0.
  - FIFO contents are discarded.

## Timing
- Start at edge s, `done` first sampled high at edge k: the entry is written at edge k with `out_cycles` = k-s.
- Capture-to-output latency is 1 cycle. With an empty FIFO, `out_valid` rises right after edge k.
- Throughput: one push and one pop per cycle.
- `overflow` asserts after the dropping edge and stays high until `rst_n`.

## Structure
- `pret_pkg` holds:
  - the state enum `pret_buf_state_e` {IDLE, RUN, HOLD};
  - the `round_sat` function, parameterised by TW/OW;
  - the default widths as localparams shared with `pret`.
- Sub-module `sync_fifo` (WIDTH=OW+CW, DEPTH) holds the storage, pointers and level. It has no knowledge of rounding or the FSM.

## Test plan
Defaults TW=13, OW=6 unless stated.
1. `start` at edge 0, `done` high at edge 64 with Bz=13'h0800 -> entry with `out_val`=16, `out_cycles`=64; `out_valid` high from the cycle after edge 64; pops when `out_ready`=1.
2. Rounding boundaries:
   - Bz=13'h003F -> 0.
   - Bz=13'h0040 -> 1.
   - Bz=13'h1FFF -> 63 (saturated).
   - With OW=TW, Bz=13'h0ABC passes through as 13'h0ABC.
3. `done` held high for 20 cycles after the rise, plus a `done` rise while in IDLE -> exactly one entry; the IDLE rise pushes nothing.
4. Five runs completed with `out_ready`=0, DEPTH=4 -> `level`=4, fifth result dropped, `overflow`=1. Then push on a full FIFO with a simultaneous pop -> accepted, `level` stays 4.
5. `start` in the same cycle as a `done` rise -> old run pushed with the correct count; the new run's `cnt` starts at 0; CW=4 with a 20-cycle run -> `out_cycles`=15 (saturated).
6. `rst_n` pulsed low mid-RUN with 2 entries queued -> `out_valid`=0, `level`=0, `overflow`=0, state IDLE; a later `done` rise produces no entry until the next `start`.
